ext_bus_master: RTL and testbench

- Initiator for the 16-bit chip-select/read/write external register bus; the counterpart of the FPGA-side register-file responder.
- Converts a single-cycle req/ack register access from a local host (test harness, bridge, or debug controller) into correctly timed bus cycles: setup, strobe, hold.
- Used to drive the SoC control/status registers (sanity, address, data, control, PC, state, mem size) without an external CPU.

---
 rtl/ext_bus_master.sv | 207 ++++++++++++++++++++
 tb/tb_ext_bus_master.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : ext_bus_master
// Purpose  : Initiator for the 16-bit chip-select/read/write external register
//            bus. Turns a single-cycle req/ack host access into a timed bus
//            cycle: SETUP (address + strobe), STROBE (cs=11), HOLD, DONE.
// Ports    : clk_i, reset_i (sync, active-low)
//            host : req_i, we_i, reg_addr_i, size32_i, wdata_i -> rdata_o,
//                   ack_o, busy_o
//            bus  : bus_addr_o, bus_data_o, bus_data_oe_o, bus_data_i,
//                   bus_read_n_o, bus_write_n_o, bus_cs_o
// Options  : EXT_BUS_MASTER_WORD32_EN - size32_i=1 runs two 16-bit bus
//            cycles (reg, reg+1) with one ack. Undefined: size32_i ignored.
// Revision : 1.0 - initial release
// ============================================================================
module ext_bus_master #(
  parameter int ADDR_WIDTH    = 25,
  parameter int DATA_WIDTH    = 16,
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 6,
  parameter int HOLD_CYCLES   = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [3:0]            reg_addr_i,
  input  logic                  size32_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o,
  output logic                  ack_o,
  output logic                  busy_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_data_o,
  output logic                  bus_data_oe_o,
  input  logic [DATA_WIDTH-1:0] bus_data_i,
  output logic                  bus_read_n_o,
  output logic                  bus_write_n_o,
  output logic [1:0]            bus_cs_o
);

  // Clamp phase lengths; the strobe minimum covers the responder's 3-stage
  // cs synchroniser plus its registered read data.
  localparam int c_setup  = (SETUP_CYCLES  < 1) ? 1 : SETUP_CYCLES;
  localparam int c_strobe = (STROBE_CYCLES < 5) ? 5 : STROBE_CYCLES;
  localparam int c_hold   = (HOLD_CYCLES   < 1) ? 1 : HOLD_CYCLES;
  localparam int c_max_ss = (c_setup > c_strobe) ? c_setup : c_strobe;
  localparam int c_max    = (c_max_ss > c_hold) ? c_max_ss : c_hold;
  localparam int c_cnt_w  = $clog2(c_max) + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic                 hi_q, hi_d;      // 1 while running the upper half
  logic                 we_q;
  logic [3:0]           reg_q;
  logic [31:0]          wdata_q;
  logic [31:0]          rdata_q;

  logic                 w_accept;
  logic                 w_cnt_zero;
  logic                 w_capture;
  logic                 w_more;          // a second half is still to run
  logic                 w_strobe_act;
  logic [3:0]           w_idx;
  logic [15:0]          w_wdata_half;
  logic [15:0]          w_rd_half;

  assign w_accept   = (state_q == ST_IDLE) && req_i;
  assign w_cnt_zero = (cnt_q == '0);
  assign w_capture  = (state_q == ST_STROBE) && w_cnt_zero && !we_q;

`ifdef EXT_BUS_MASTER_WORD32_EN
  logic size32_q;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      size32_q <= 1'b0;
    end else if (w_accept) begin
      size32_q <= size32_i;
    end
  end

  assign w_more = size32_q && !hi_q;
`else
  logic w_unused;
  assign w_unused = size32_i;
  assign w_more   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register and phase counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          state_d = ST_SETUP;
          cnt_d   = c_cnt_w'(c_setup - 1);
          hi_d    = 1'b0;
        end
      end
      ST_SETUP: begin
        if (w_cnt_zero) begin
          state_d = ST_STROBE;
          cnt_d   = c_cnt_w'(c_strobe - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STROBE: begin
        if (w_cnt_zero) begin
          state_d = ST_HOLD;
          cnt_d   = c_cnt_w'(c_hold - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (w_cnt_zero) begin
          if (w_more) begin
            state_d = ST_SETUP;
            cnt_d   = c_cnt_w'(c_setup - 1);
            hi_d    = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latch and read-data capture
  // ---------------------------------------------------------------------------
  assign w_rd_half = 16'(bus_data_i);

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      we_q    <= 1'b0;
      reg_q   <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else if (w_accept) begin
      we_q    <= we_i;
      reg_q   <= reg_addr_i;
      wdata_q <= wdata_i;
      rdata_q <= 32'd0;
    end else if (w_capture) begin
      if (hi_q) begin
        rdata_q[31:16] <= w_rd_half;
      end else begin
        rdata_q[15:0]  <= w_rd_half;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bus outputs, decoded from registered state only
  // ---------------------------------------------------------------------------
  // Strobes stay asserted through the first HOLD cycle so they never move
  // in the same cycle cs drops.
  assign w_strobe_act = (state_q == ST_SETUP) || (state_q == ST_STROBE) ||
                        ((state_q == ST_HOLD) && (cnt_q == c_cnt_w'(c_hold - 1)));

  assign w_idx        = reg_q + {3'b000, hi_q};   // upper half wraps mod 16
  assign w_wdata_half = hi_q ? wdata_q[31:16] : wdata_q[15:0];

  assign bus_addr_o    = {{(ADDR_WIDTH-5){1'b0}}, w_idx, 1'b0};
  assign bus_data_o    = DATA_WIDTH'(w_wdata_half);
  assign bus_data_oe_o = w_strobe_act && we_q;
  assign bus_read_n_o  = !(w_strobe_act && !we_q);
  assign bus_write_n_o = !(w_strobe_act && we_q);
  assign bus_cs_o      = (state_q == ST_STROBE) ? 2'b11 : 2'b00;

  assign rdata_o = rdata_q;
  assign ack_o   = (state_q == ST_DONE);
  assign busy_o  = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ext_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ext_bus_master
// Purpose  : Self-checking bench for ext_bus_master with a register-file
//            responder on the bus and a register-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ext_bus_master;

  localparam int S   = 2;
  localparam int T   = 6;
  localparam int H   = 2;
  // Cycles counted from the req cycle through the ack cycle, inclusive.
  localparam int LAT   = S + T + H + 2;
  localparam int LAT32 = 2 * (S + T + H) + 2;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        req_i;
  logic        we_i;
  logic [3:0]  reg_addr_i;
  logic        size32_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic        busy_o;
  logic [24:0] bus_addr_o;
  logic [15:0] bus_data_o;
  logic        bus_data_oe_o;
  logic [15:0] bus_data_i;
  logic        bus_read_n_o;
  logic        bus_write_n_o;
  logic [1:0]  bus_cs_o;

  always #5 clk = ~clk;

  ext_bus_master #(
    .ADDR_WIDTH(25), .DATA_WIDTH(16),
    .SETUP_CYCLES(S), .STROBE_CYCLES(T), .HOLD_CYCLES(H)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .req_i(req_i), .we_i(we_i),
    .reg_addr_i(reg_addr_i), .size32_i(size32_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .ack_o(ack_o), .busy_o(busy_o),
    .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o),
    .bus_data_oe_o(bus_data_oe_o), .bus_data_i(bus_data_i),
    .bus_read_n_o(bus_read_n_o), .bus_write_n_o(bus_write_n_o),
    .bus_cs_o(bus_cs_o)
  );

  int checks   = 0;
  int failures = 0;

  function automatic logic [15:0] init_val(input int i);
    case (i)
      0:       return 16'h50FE;
      11:      return 16'h0000;
      12:      return 16'h0001;
      default: return 16'hA500 + 16'(i);
    endcase
  endfunction

  // Reference model: the register file as the host should see it.
  logic [15:0] exp_regs [16];

  // ---------------------------------------------------------------------------
  // Responder + bus monitor (register file behind the bus)
  // ---------------------------------------------------------------------------
  logic [15:0] resp_regs [16];
  bit          resp_ready   = 1'b0;
  logic [1:0]  prev_cs      = 2'b00;
  int          edge_cnt     = 0;
  int          ack_cnt      = 0;
  int          stab_viol    = 0;
  int          oe_viol      = 0;
  int          cs_hi_wr_cyc = 0;
  logic [24:0] edge_addr [$];
  logic [24:0] snap_addr;
  logic        snap_rn, snap_wn, snap_oe;
  logic [15:0] snap_data;

  assign bus_data_i = (bus_cs_o == 2'b11 && bus_read_n_o == 1'b0) ?
                      resp_regs[bus_addr_o[4:1]] : 16'hDEAD;

  always @(negedge clk) begin
    if (!resp_ready) begin
      for (int i = 0; i < 16; i++) resp_regs[i] = init_val(i);
      resp_ready = 1'b1;
    end
    if (ack_o === 1'b1) ack_cnt++;
    if (bus_data_oe_o === 1'b1 && bus_read_n_o === 1'b0) oe_viol++;
    if (bus_cs_o === 2'b11) begin
      if (prev_cs !== 2'b11) begin
        edge_cnt++;
        edge_addr.push_back(bus_addr_o);
        snap_addr = bus_addr_o;
        snap_rn   = bus_read_n_o;
        snap_wn   = bus_write_n_o;
        snap_oe   = bus_data_oe_o;
        snap_data = bus_data_o;
        if (bus_write_n_o === 1'b0 && bus_addr_o[4:1] != 4'd0)
          resp_regs[bus_addr_o[4:1]] = bus_data_o;
      end else if ({bus_addr_o, bus_read_n_o, bus_write_n_o, bus_data_oe_o, bus_data_o} !==
                   {snap_addr, snap_rn, snap_wn, snap_oe, snap_data}) begin
        stab_viol++;
      end
      if (bus_write_n_o === 1'b0 && bus_data_oe_o === 1'b1) cs_hi_wr_cyc++;
    end
    prev_cs = bus_cs_o;
  end

  // ---------------------------------------------------------------------------
  // One host access. req_i is raised in cycle 1; cycles plo..phi re-pulse it.
  // Returns in the cycle after ack (or after the cycle budget expires).
  // ---------------------------------------------------------------------------
  task automatic do_access(input bit we, input logic [3:0] r, input logic [31:0] wd,
                           input bit s32, input int plo, input int phi,
                           output logic [31:0] rd, output int lat, output int edges,
                           output logic [24:0] addr0);
    int e0;
    int cyc;
    bit got;
    e0  = edge_cnt;
    got = 1'b0;
    lat = -1;
    rd  = 32'hxxxx_xxxx;
    we_i = we; reg_addr_i = r; wdata_i = wd; size32_i = s32; req_i = 1'b1;
    cyc = 1;
    @(posedge clk); #1;
    for (int k = 0; k < 100; k++) begin
      cyc++;
      req_i = (cyc >= plo && cyc <= phi);
      if (ack_o === 1'b1) begin
        got = 1'b1;
        lat = cyc;
        rd  = rdata_o;
        break;
      end
      @(posedge clk); #1;
    end
    req_i = 1'b0;
    edges = edge_cnt - e0;
    addr0 = (edges > 0) ? edge_addr[e0] : 25'h1FFFFFF;
    if (got) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b0; req_i = 1'b0; we_i = 1'b0; reg_addr_i = 4'd0;
    size32_i = 1'b0; wdata_i = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus_cs_o !== 2'b00) begin failures++; $display("FAIL reset_cs: got %b expected 00", bus_cs_o); end
    checks++; if (bus_read_n_o !== 1'b1) begin failures++; $display("FAIL reset_read_n: got %b expected 1", bus_read_n_o); end
    checks++; if (bus_write_n_o !== 1'b1) begin failures++; $display("FAIL reset_write_n: got %b expected 1", bus_write_n_o); end
    checks++; if (bus_data_oe_o !== 1'b0) begin failures++; $display("FAIL reset_oe: got %b expected 0", bus_data_oe_o); end
    checks++; if (bus_addr_o !== 25'd0) begin failures++; $display("FAIL reset_addr: got %h expected 0", bus_addr_o); end
    checks++; if (bus_data_o !== 16'd0) begin failures++; $display("FAIL reset_data: got %h expected 0", bus_data_o); end
    checks++; if (rdata_o !== 32'd0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", rdata_o); end
    checks++; if (ack_o !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b expected 0", ack_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    reset_i = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read_sanity();
    logic [31:0] rd; int lat, edges; logic [24:0] a0;
    do_access(1'b0, 4'd0, 32'd0, 1'b0, 1000, 0, rd, lat, edges, a0);
    checks++; if (lat !== LAT) begin failures++; $display("FAIL sanity_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (edges !== 1) begin failures++; $display("FAIL sanity_cs_edges: got %0d expected 1", edges); end
    checks++; if (a0 !== 25'h0000000) begin failures++; $display("FAIL sanity_addr: got %h expected 0000000", a0); end
    checks++; if (rd !== {16'h0, exp_regs[0]}) begin failures++; $display("FAIL sanity_rdata: got %h expected %h", rd, {16'h0, exp_regs[0]}); end
  endtask

  task automatic test_write();
    logic [31:0] rd; int lat, edges; logic [24:0] a0; int w0, s0;
    w0 = cs_hi_wr_cyc; s0 = stab_viol;
    do_access(1'b1, 4'd3, 32'h0000_1234, 1'b0, 1000, 0, rd, lat, edges, a0);
    exp_regs[3] = 16'h1234;
    checks++; if (a0 !== 25'h0000006) begin failures++; $display("FAIL write_addr: got %h expected 0000006", a0); end
    checks++; if (cs_hi_wr_cyc - w0 !== T) begin failures++; $display("FAIL write_cs_hi_cycles: got %0d expected %0d", cs_hi_wr_cyc - w0, T); end
    checks++; if (snap_data !== 16'h1234) begin failures++; $display("FAIL write_data: got %h expected 1234", snap_data); end
    checks++; if (stab_viol !== s0) begin failures++; $display("FAIL write_stable: got %0d changes expected 0", stab_viol - s0); end
    checks++; if (lat !== LAT) begin failures++; $display("FAIL write_latency: got %0d expected %0d", lat, LAT); end
    do_access(1'b0, 4'd3, 32'd0, 1'b0, 1000, 0, rd, lat, edges, a0);
    checks++; if (rd !== {16'h0, exp_regs[3]}) begin failures++; $display("FAIL write_readback: got %h expected %h", rd, {16'h0, exp_regs[3]}); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; int lat, edges; logic [24:0] a0; int o0;
    o0 = oe_viol;
    do_access(1'b1, 4'd1, 32'h0000_BEEF, 1'b0, 1000, 0, rd, lat, edges, a0);
    exp_regs[1] = 16'hBEEF;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL b2b_busy_after_ack: got %b expected 0", busy_o); end
    do_access(1'b0, 4'd1, 32'd0, 1'b0, 1000, 0, rd, lat, edges, a0);
    checks++; if (lat !== LAT) begin failures++; $display("FAIL b2b_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (edges !== 1) begin failures++; $display("FAIL b2b_cs_edges: got %0d expected 1", edges); end
    checks++; if (rd !== {16'h0, exp_regs[1]}) begin failures++; $display("FAIL b2b_rdata: got %h expected %h", rd, {16'h0, exp_regs[1]}); end
    checks++; if (oe_viol !== o0) begin failures++; $display("FAIL b2b_oe_read_overlap: got %0d expected 0", oe_viol - o0); end
  endtask

  task automatic test_req_during_strobe();
    logic [31:0] rd; int lat, edges; logic [24:0] a0; int k0, e1;
    k0 = ack_cnt;
    // cycles 5 and 6 fall inside STROBE (cycles 4..9)
    do_access(1'b0, 4'd7, 32'd0, 1'b0, 5, 6, rd, lat, edges, a0);
    e1 = edge_cnt;
    repeat (LAT + 4) begin @(posedge clk); #1; end
    checks++; if (lat !== LAT) begin failures++; $display("FAIL poke_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (rd !== {16'h0, exp_regs[7]}) begin failures++; $display("FAIL poke_rdata: got %h expected %h", rd, {16'h0, exp_regs[7]}); end
    checks++; if (ack_cnt - k0 !== 1) begin failures++; $display("FAIL poke_ack_count: got %0d expected 1", ack_cnt - k0); end
    checks++; if (edges + (edge_cnt - e1) !== 1) begin failures++; $display("FAIL poke_cs_edges: got %0d expected 1", edges + (edge_cnt - e1)); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int lat, edges; logic [24:0] a0; int k0;
    k0 = ack_cnt;
    we_i = 1'b0; reg_addr_i = 4'd2; size32_i = 1'b0; wdata_i = 32'd0; req_i = 1'b1;
    @(posedge clk); #1;
    req_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (bus_cs_o !== 2'b11) begin failures++; $display("FAIL rstmid_in_strobe: got %b expected 11", bus_cs_o); end
    reset_i = 1'b0;
    @(posedge clk); #1;
    reset_i = 1'b1;
    checks++; if (bus_cs_o !== 2'b00) begin failures++; $display("FAIL rstmid_cs: got %b expected 00", bus_cs_o); end
    checks++; if ({bus_read_n_o, bus_write_n_o} !== 2'b11) begin failures++; $display("FAIL rstmid_strobes: got %b expected 11", {bus_read_n_o, bus_write_n_o}); end
    checks++; if (bus_data_oe_o !== 1'b0) begin failures++; $display("FAIL rstmid_oe: got %b expected 0", bus_data_oe_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", busy_o); end
    repeat (LAT + 2) begin @(posedge clk); #1; end
    checks++; if (ack_cnt !== k0) begin failures++; $display("FAIL rstmid_no_ack: got %0d acks expected 0", ack_cnt - k0); end
    do_access(1'b0, 4'd0, 32'd0, 1'b0, 1000, 0, rd, lat, edges, a0);
    checks++; if (lat !== LAT) begin failures++; $display("FAIL rstmid_next_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (rd !== {16'h0, exp_regs[0]}) begin failures++; $display("FAIL rstmid_next_rdata: got %h expected %h", rd, {16'h0, exp_regs[0]}); end
  endtask

  task automatic test_size32();
    logic [31:0] rd; int lat, edges; logic [24:0] a0; int k0, e0;
    k0 = ack_cnt;
    e0 = edge_cnt;
`ifdef EXT_BUS_MASTER_WORD32_EN
    do_access(1'b0, 4'd11, 32'd0, 1'b1, 1000, 0, rd, lat, edges, a0);
    checks++; if (edges !== 2) begin failures++; $display("FAIL w32_cs_edges: got %0d expected 2", edges); end
    checks++; if (a0 !== 25'h16) begin failures++; $display("FAIL w32_addr_lo: got %h expected 16", a0); end
    checks++; if (edges == 2 && edge_addr[e0 + 1] !== 25'h18) begin failures++; $display("FAIL w32_addr_hi: got %h expected 18", edge_addr[e0 + 1]); end
    checks++; if (lat !== LAT32) begin failures++; $display("FAIL w32_latency: got %0d expected %0d", lat, LAT32); end
    checks++; if (rd !== {exp_regs[12], exp_regs[11]}) begin failures++; $display("FAIL w32_rdata: got %h expected %h", rd, {exp_regs[12], exp_regs[11]}); end
`else
    do_access(1'b0, 4'd12, 32'd0, 1'b1, 1000, 0, rd, lat, edges, a0);
    checks++; if (edges !== 1) begin failures++; $display("FAIL s32off_cs_edges: got %0d expected 1", edges); end
    checks++; if (a0 !== 25'h18) begin failures++; $display("FAIL s32off_addr: got %h expected 18", a0); end
    checks++; if (lat !== LAT) begin failures++; $display("FAIL s32off_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (rd !== {16'h0, exp_regs[12]}) begin failures++; $display("FAIL s32off_rdata: got %h expected %h", rd, {16'h0, exp_regs[12]}); end
`endif
    checks++; if (ack_cnt - k0 !== 1) begin failures++; $display("FAIL s32_ack_count: got %0d expected 1", ack_cnt - k0); end
  endtask

  task automatic test_random();
    logic [31:0] rd; int lat, edges; logic [24:0] a0;
    bit we; logic [3:0] r; logic [31:0] wd; int gap;
    for (int n = 0; n < 24; n++) begin
      we  = 1'($urandom_range(0, 1));
      r   = 4'($urandom_range(1, 15));
      wd  = $urandom;
      gap = $urandom_range(0, 3);
      do_access(we, r, wd, 1'b0, 1000, 0, rd, lat, edges, a0);
      checks++; if (lat !== LAT) begin failures++; $display("FAIL rnd%0d_latency: got %0d expected %0d", n, lat, LAT); end
      checks++; if (edges !== 1) begin failures++; $display("FAIL rnd%0d_cs_edges: got %0d expected 1", n, edges); end
      checks++; if (a0 !== 25'({r, 1'b0})) begin failures++; $display("FAIL rnd%0d_addr: got %h expected %h", n, a0, 25'({r, 1'b0})); end
      if (we) begin
        exp_regs[r] = wd[15:0];
      end else begin
        checks++; if (rd !== {16'h0, exp_regs[r]}) begin failures++; $display("FAIL rnd%0d_rdata: got %h expected %h", n, rd, {16'h0, exp_regs[r]}); end
      end
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_bus_rules();
    checks++; if (oe_viol !== 0) begin failures++; $display("FAIL rule_oe_with_read: got %0d expected 0", oe_viol); end
    checks++; if (stab_viol !== 0) begin failures++; $display("FAIL rule_stable_cs_high: got %0d expected 0", stab_viol); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) exp_regs[i] = init_val(i);
    test_reset();
    test_read_sanity();
    test_write();
    test_back_to_back();
    test_req_during_strobe();
    test_reset_mid();
    test_size32();
    test_random();
    test_bus_rules();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
